// File: rtl/rifl_axis_pkt_fifo_pkg.sv
// rifl_axis_pkt_fifo shared types.
// Write-side FSM states, entry packing, counter width.
package rifl_axis_pkt_fifo_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CUT   = 2'd1,
    DROP  = 2'd2
  } wr_state_e;

  localparam int DROP_CNT_W = 16;

  localparam int DW_MAX  = 512;
  localparam int KW_MAX  = DW_MAX / 8;
  localparam int ENT_MAX = DW_MAX + KW_MAX + 1;

  // Packs {last, keep, data} LSB-aligned for a data width of dw.
  function automatic logic [ENT_MAX-1:0] pack_entry(
    input int                 dw,
    input logic               last,
    input logic [KW_MAX-1:0]  keep,
    input logic [DW_MAX-1:0]  data
  );
    logic [ENT_MAX-1:0] e;
    e = '0;
    for (int i = 0; i < DW_MAX; i++)
      if (i < dw) e[i] = data[i];
    for (int i = 0; i < KW_MAX; i++)
      if (i < dw / 8) e[dw + i] = keep[i];
    e[dw + dw / 8] = last;
    return e;
  endfunction

endpackage

// File: rtl/rifl_sdp_ram.sv
// rifl_sdp_ram: simple dual-port RAM.
// Registered read port doubles as the stream output register.
module rifl_sdp_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [W-1:0]             i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [W-1:0]             o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register: holds its value unless a new entry is loaded.
  always_ff @(posedge clk) begin
    if (rst)          r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rifl_axis_pkt_fifo.sv
// rifl_axis_pkt_fifo: store-and-forward AXI4-Stream packet FIFO.
// RIFL_AXIS_PKT_FIFO_DROP_EN: drop overflowing packets instead of cut-through.
module rifl_axis_pkt_fifo
  import rifl_axis_pkt_fifo_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DWIDTH-1:0]        s_axis_tdata,
  input  logic [DWIDTH/8-1:0]      s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DWIDTH-1:0]        m_axis_tdata,
  output logic [DWIDTH/8-1:0]      m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = DWIDTH / 8;
  localparam int EW = DWIDTH + KW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_wr_commit;
  logic [PW-1:0] r_rd_ptr;
  wr_state_e     r_state;
  logic          r_live;
  logic          r_m_valid;

  logic [PW-1:0] w_cnt;
  logic          w_full;
  logic          w_avail;
  logic          w_load;
  logic          w_wr;
  logic [EW-1:0] w_wr_data;
  logic [EW-1:0] w_rd_data;

  assign w_cnt   = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_cnt == PW'(DEPTH));
  assign w_avail = (r_rd_ptr != r_wr_commit);
  assign w_load  = w_avail & (~r_m_valid | m_axis_tready);

  assign w_wr_data = EW'(pack_entry(DWIDTH, s_axis_tlast,
                                    KW_MAX'(s_axis_tkeep),
                                    DW_MAX'(s_axis_tdata)));

`ifdef RIFL_AXIS_PKT_FIFO_DROP_EN
  logic                  w_ovf;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  assign s_axis_tready = r_live;
  assign w_wr  = s_axis_tvalid & r_live & ~w_full
               & (r_state == ACCUM);
  assign w_ovf = s_axis_tvalid & r_live & w_full
               & (r_state == ACCUM);
  assign drop_cnt = r_drop_cnt;

  // Write pointer, commit point and drop FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_state     <= ACCUM;
      r_drop_cnt  <= '0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_ovf) begin
            r_wr_ptr <= r_wr_commit;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (!s_axis_tlast) r_state <= DROP;
          end else if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (s_axis_tlast) r_wr_commit <= r_wr_ptr + 1'b1;
          end
        end
        DROP: begin
          if (s_axis_tvalid & r_live & s_axis_tlast) r_state <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end
`else
  assign s_axis_tready = r_live & ~w_full;
  assign w_wr     = s_axis_tvalid & s_axis_tready;
  assign drop_cnt = '0;

  // Write pointer, commit point and cut-through FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_state     <= ACCUM;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_full && r_wr_commit == r_rd_ptr) begin
            r_state     <= CUT;
            r_wr_commit <= r_wr_ptr;
          end else if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (s_axis_tlast) r_wr_commit <= r_wr_ptr + 1'b1;
          end
        end
        CUT: begin
          if (w_wr) begin
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            r_wr_commit <= r_wr_ptr + 1'b1;
            if (s_axis_tlast) r_state <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end
`endif

  // Write side is held off for the whole reset cycle.
  always_ff @(posedge clk) begin
    r_live <= ~rst;
  end

  // Read pointer and output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_m_valid <= 1'b1;
      end else if (m_axis_tready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  rifl_sdp_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_load),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign m_axis_tdata  = w_rd_data[DWIDTH-1:0];
  assign m_axis_tkeep  = w_rd_data[DWIDTH +: KW];
  assign m_axis_tlast  = w_rd_data[EW-1];
  assign m_axis_tvalid = r_m_valid;
  assign fifo_cnt      = w_cnt;

endmodule
